mcu_subsys_bus_arbiter: RTL

MCU_SUBSYS_BUS_ARBITER -- requirements
Module: mcu_subsys_bus_arbiter

---
 rtl/mcu_subsys_bus_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mcu_subsys_bus_arbiter.sv
// Two-master round-robin arbiter in front of the host bridge, with a per-transaction
// BUSY-cycle timeout that completes the stalled master with an error read value.
module mcu_subsys_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        sys_clk,
    input  logic        rst,

    input  logic        m0_mem_valid,
    output logic        m0_mem_ready,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic [31:0] m0_mem_rdata,

    input  logic        m1_mem_valid,
    output logic        m1_mem_ready,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic [31:0] m1_mem_rdata,

    output logic        s_mem_valid,
    input  logic        s_mem_ready,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic [31:0] s_mem_rdata,

    output logic        timeout_flag,
    output logic [31:0] timeout_addr,
    input  logic        timeout_clr
);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        grant;       // 0 = m0, 1 = m1
    logic        last_grant;
    logic [15:0] cnt;

    logic        g_valid;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [3:0]  g_wstrb;
    logic        busy;
    logic        err;
    logic        complete;
    logic        timeout_hit;
    logic        ready_any;
    logic [31:0] ready_data;

    // Combinational outputs are masked by rst so an in-flight completion cannot leak a ready.
    always_comb begin
        g_valid     = grant ? m1_mem_valid : m0_mem_valid;
        g_addr      = grant ? m1_mem_addr  : m0_mem_addr;
        g_wdata     = grant ? m1_mem_wdata : m0_mem_wdata;
        g_wstrb     = grant ? m1_mem_wstrb : m0_mem_wstrb;

        busy        = (state == BUSY) && !rst;
        err         = (state == ERR)  && !rst;
        complete    = busy && g_valid && s_mem_ready;
        timeout_hit = busy && g_valid && !s_mem_ready && (cnt == CNT_LAST);
        ready_any   = complete || err;
        ready_data  = err ? ERR_RDATA : s_mem_rdata;

        s_mem_valid = busy && g_valid;
        s_mem_addr  = busy ? g_addr  : '0;
        s_mem_wdata = busy ? g_wdata : '0;
        s_mem_wstrb = busy ? g_wstrb : '0;

        m0_mem_ready = ready_any && !grant;
        m1_mem_ready = ready_any &&  grant;
        m0_mem_rdata = (ready_any && !grant) ? ready_data : '0;
        m1_mem_rdata = (ready_any &&  grant) ? ready_data : '0;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            cnt          <= '0;
            timeout_flag <= 1'b0;
            timeout_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_mem_valid || m1_mem_valid) begin
                        grant <= (m0_mem_valid && m1_mem_valid) ? !last_grant : m1_mem_valid;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!g_valid) begin
                        state <= IDLE;
                    end else if (s_mem_ready) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_addr <= g_addr;
                        state        <= ERR;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ERR: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end else if (timeout_clr) begin
                timeout_flag <= 1'b0;
            end
        end
    end

endmodule
